// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_fsm
//  Purpose  : Main control FSM for a multi-cycle MIPS-style datapath.
//             It sequences each instruction through IF / ID / EXE / MEM / WB
//             and decodes the datapath strobes from state, Op and Funct.
//             The register file writes on the falling edge of CLK, so every
//             strobe here settles from state_q well before that edge.
//  Ports    : CLK        - clock; state advances on the rising edge
//             Reset      - asynchronous active-low reset (forces S_IF)
//             Op, Funct  - IR[31:26] and IR[5:0]
//             Zero       - ALU zero flag, used in S_EXE_BR
//             PCWre, IRWre, RegWrite, RegDst, ALUSrcA, ALUSrcB, ExtSel,
//             ALUOp, MemRead, MemWrite, DBDataSrc, PCSrc - datapath controls
//             State      - current state code (debug)
//             InsnCount  - PC-update counter (only with CTRL_INSN_COUNT_EN)
//  Config   : `define CTRL_INSN_COUNT_EN adds the InsnCount output/counter.
//  ALUOp    : 0=add 1=sub 2=or 3=and 4=slt 5=sll
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm #(
  parameter logic [5:0]  HALT_OP = 6'b111111,
  parameter int unsigned ALUOP_W = 3
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  output logic               PCWre,
  output logic               IRWre,
  output logic               RegWrite,
  output logic [1:0]         RegDst,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic               ExtSel,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               DBDataSrc,
  output logic [2:0]         PCSrc,
`ifdef CTRL_INSN_COUNT_EN
  output logic [31:0]        InsnCount,
`endif
  output logic [3:0]         State
);

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EXE_AL = 4'd2,
    S_WB_AL  = 4'd3,
    S_EXE_BR = 4'd4,
    S_EXE_LS = 4'd5,
    S_MEM    = 4'd6,
    S_WB_LD  = 4'd7,
    S_HALT   = 4'd8
  } state_e;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_JAL   = 6'b000011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_BNE   = 6'b000101;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;

  localparam logic [5:0] c_FN_SLL   = 6'b000000;
  localparam logic [5:0] c_FN_JR    = 6'b001000;
  localparam logic [5:0] c_FN_JALR  = 6'b001001;
  localparam logic [5:0] c_FN_ADD   = 6'b100000;
  localparam logic [5:0] c_FN_SUB   = 6'b100010;
  localparam logic [5:0] c_FN_AND   = 6'b100100;
  localparam logic [5:0] c_FN_OR    = 6'b100101;
  localparam logic [5:0] c_FN_SLT   = 6'b101010;

  localparam logic [ALUOP_W-1:0] c_ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] c_ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] c_ALU_OR  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] c_ALU_AND = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] c_ALU_SLT = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] c_ALU_SLL = ALUOP_W'(5);

  state_e state_q, state_d;

  logic w_rtype, w_halt, w_jr, w_jalr, w_sll, w_addi, w_ori, w_lw, w_sw;
  logic w_beq, w_bne;
  logic [ALUOP_W-1:0] w_alu_fn;

  assign w_rtype = (Op == c_OP_RTYPE);
  assign w_halt  = (Op == HALT_OP);
  assign w_jr    = w_rtype && (Funct == c_FN_JR);
  assign w_jalr  = w_rtype && (Funct == c_FN_JALR);
  assign w_sll   = w_rtype && (Funct == c_FN_SLL);
  assign w_addi  = (Op == c_OP_ADDI);
  assign w_ori   = (Op == c_OP_ORI);
  assign w_lw    = (Op == c_OP_LW);
  assign w_sw    = (Op == c_OP_SW);
  assign w_beq   = (Op == c_OP_BEQ);
  assign w_bne   = (Op == c_OP_BNE);

  // ALU function for the arithmetic/logic path; unlisted R-type functs add.
  always_comb begin
    w_alu_fn = c_ALU_ADD;
    if (w_ori) begin
      w_alu_fn = c_ALU_OR;
    end else if (w_rtype) begin
      case (Funct)
        c_FN_SUB: w_alu_fn = c_ALU_SUB;
        c_FN_AND: w_alu_fn = c_ALU_AND;
        c_FN_OR:  w_alu_fn = c_ALU_OR;
        c_FN_SLT: w_alu_fn = c_ALU_SLT;
        c_FN_SLL: w_alu_fn = c_ALU_SLL;
        default:  w_alu_fn = c_ALU_ADD;
      endcase
    end
  end

  always_comb begin
    state_d   = S_IF;
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWrite  = 1'b0;
    RegDst    = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    ALUOp     = c_ALU_ADD;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    DBDataSrc = 1'b0;
    PCSrc     = 3'b000;
    case (state_q)
      S_IF: begin
        IRWre   = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        // Halt is checked first so HALT_OP wins over any other decode.
        if (w_halt) begin
          state_d = S_HALT;
        end else if (Op == c_OP_J) begin
          PCSrc = 3'b100;
          PCWre = 1'b1;
        end else if (Op == c_OP_JAL) begin
          PCSrc = 3'b011;
          PCWre = 1'b1;
        end else if (w_jr) begin
          PCSrc = 3'b010;
          PCWre = 1'b1;
        end else if (w_jalr) begin
          PCSrc = 3'b101;
          PCWre = 1'b1;
        end else if (w_beq || w_bne) begin
          state_d = S_EXE_BR;
        end else if (w_lw || w_sw) begin
          state_d = S_EXE_LS;
        end else if (w_rtype || w_addi || w_ori) begin
          state_d = S_EXE_AL;
        end else begin
          // Unknown opcode retires as a nop.
          PCWre = 1'b1;
        end
      end
      S_EXE_AL: begin
        ALUSrcB = w_addi || w_ori;
        ExtSel  = w_addi;
        ALUSrcA = w_sll;
        ALUOp   = w_alu_fn;
        state_d = S_WB_AL;
      end
      S_WB_AL: begin
        RegWrite = 1'b1;
        RegDst   = w_rtype ? 2'b01 : 2'b00;
        PCWre    = 1'b1;
      end
      S_EXE_BR: begin
        ALUOp = c_ALU_SUB;
        PCWre = 1'b1;
        if ((w_beq && Zero) || (w_bne && !Zero)) PCSrc = 3'b001;
      end
      S_EXE_LS: begin
        ALUSrcB = 1'b1;
        ExtSel  = 1'b1;
        ALUOp   = c_ALU_ADD;
        state_d = S_MEM;
      end
      S_MEM: begin
        if (w_lw) begin
          MemRead = 1'b1;
          state_d = S_WB_LD;
        end else begin
          MemWrite = 1'b1;
          PCWre    = 1'b1;
        end
      end
      S_WB_LD: begin
        RegWrite  = 1'b1;
        RegDst    = 2'b00;
        DBDataSrc = 1'b1;
        PCWre     = 1'b1;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_q <= S_IF;
    else        state_q <= state_d;
  end

  assign State = state_q;

`ifdef CTRL_INSN_COUNT_EN
  logic [31:0] insn_count_q;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)     insn_count_q <= 32'd0;
    else if (PCWre) insn_count_q <= insn_count_q + 32'd1;
  end

  assign InsnCount = insn_count_q;
`endif

endmodule
`default_nettype wire
